// File: rtl/alu_cmd_seq.sv
// Operand/command sequencer for the combinational ALU: a debounced pushbutton steps through
// load A, load B, load op, execute and show result.
module alu_cmd_seq #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SETTLE_CYCLES   = 2,
    parameter int CNT_W           = 20
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [5:0]  sw_i,
    input  logic [1:0]  op_sw_i,
    input  logic        btn_i,
    input  logic [11:0] alu_data_i,
    output logic [5:0]  A_o,
    output logic [5:0]  B_o,
    output logic [1:0]  Op_o,
    output logic        Led_o,
    output logic [11:0] result_o,
    output logic        valid_o,
    output logic        err_o,
    output logic [2:0]  state_o
);

    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {
        LOAD_A  = 3'd0,
        LOAD_B  = 3'd1,
        LOAD_OP = 3'd2,
        EXEC    = 3'd3,
        SHOW    = 3'd4
    } state_t;

    state_t             state, state_nxt;
    logic               sync1, sync2, db, db_d, press;
    logic [CNT_W-1:0]   db_cnt;
    logic [SET_W-1:0]   settle_cnt;
    logic               ld_a, ld_b, ld_op, div0, capture, clr_flags;

    assign state_o = state;

    always_comb begin
        state_nxt = state;
        ld_a      = 1'b0;
        ld_b      = 1'b0;
        ld_op     = 1'b0;
        div0      = 1'b0;
        capture   = 1'b0;
        clr_flags = 1'b0;
        case (state)
            LOAD_A: if (press) begin
                ld_a      = 1'b1;
                state_nxt = LOAD_B;
            end
            LOAD_B: if (press) begin
                ld_b      = 1'b1;
                state_nxt = LOAD_OP;
            end
            LOAD_OP: if (press) begin
                ld_op = 1'b1;
                // Divide by zero never reaches the ALU; the error is flagged directly.
                if (op_sw_i == 2'b11 && B_o == 6'd0) begin
                    div0      = 1'b1;
                    state_nxt = SHOW;
                end else begin
                    state_nxt = EXEC;
                end
            end
            EXEC: if (settle_cnt == SET_W'(SETTLE_CYCLES - 1)) begin
                capture   = 1'b1;
                state_nxt = SHOW;
            end
            SHOW: if (press) begin
                clr_flags = 1'b1;
                state_nxt = LOAD_A;
            end
            default: state_nxt = LOAD_A;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            db         <= 1'b0;
            db_d       <= 1'b0;
            press      <= 1'b0;
            db_cnt     <= '0;
            settle_cnt <= '0;
            state      <= LOAD_A;
            Led_o      <= 1'b1;
            A_o        <= '0;
            B_o        <= '0;
            Op_o       <= '0;
            result_o   <= '0;
            valid_o    <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            sync1 <= btn_i;
            sync2 <= sync1;
            // Level must disagree for DEBOUNCE_CYCLES consecutive cycles before db follows.
            if (sync2 != db) begin
                if (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    db     <= sync2;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + CNT_W'(1);
                end
            end else begin
                db_cnt <= '0;
            end
            db_d  <= db;
            press <= db & ~db_d;

            state <= state_nxt;
            Led_o <= (state_nxt == LOAD_A) || (state_nxt == LOAD_B) || (state_nxt == LOAD_OP);

            if (state == EXEC) settle_cnt <= settle_cnt + SET_W'(1);
            else               settle_cnt <= '0;

            if (ld_a) begin
                A_o     <= sw_i;
                valid_o <= 1'b0;
                err_o   <= 1'b0;
            end
            if (ld_b)  B_o  <= sw_i;
            if (ld_op) Op_o <= op_sw_i;
            if (div0) begin
                result_o <= 12'hFFF;
                err_o    <= 1'b1;
                valid_o  <= 1'b0;
            end
            if (capture) begin
                result_o <= alu_data_i;
                valid_o  <= 1'b1;
            end
            if (clr_flags) begin
                valid_o <= 1'b0;
                err_o   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Bench for alu_cmd_seq: a transaction-level model of the button-driven sequence is compared
// against the DUT on every falling edge, with literal expectations pinning the model.
module tb_alu_cmd_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  sw;
    logic [1:0]  op_sw;
    logic        btn;
    logic [11:0] alu_data;
    logic [5:0]  a_o, b_o;
    logic [1:0]  op_o;
    logic        led_o, valid_o, err_o;
    logic [11:0] result_o;
    logic [2:0]  state_o;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    // Model of the user-visible sequencer state
    int          m_state;
    logic [5:0]  m_a, m_b;
    logic [1:0]  m_op;
    logic [11:0] m_res;
    logic        m_valid, m_err;

    always #5 clk = ~clk;

    alu_cmd_seq #(.DEBOUNCE_CYCLES(4), .SETTLE_CYCLES(2), .CNT_W(20)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .sw_i(sw), .op_sw_i(op_sw), .btn_i(btn),
        .alu_data_i(alu_data), .A_o(a_o), .B_o(b_o), .Op_o(op_o), .Led_o(led_o),
        .result_o(result_o), .valid_o(valid_o), .err_o(err_o), .state_o(state_o)
    );

    function automatic logic [11:0] alu_fn(logic [5:0] a, logic [5:0] b, logic [1:0] op);
        int ia, ib, r;
        ia = $signed(a);
        ib = $signed(b);
        case (op)
            2'b00: r = ia + ib;
            2'b01: r = ia - ib;
            2'b10: r = ia * ib;
            default: r = (ib == 0) ? -1 : ia / ib;
        endcase
        return r[11:0];
    endfunction

    // Combinational ALU in front of the DUT
    always_comb alu_data = led_o ? {a_o, b_o} : alu_fn(a_o, b_o, op_o);

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("state",  32'(state_o),  32'(m_state));
            chk("led",    32'(led_o),    32'(m_state < 3));
            chk("A",      32'(a_o),      32'(m_a));
            chk("B",      32'(b_o),      32'(m_b));
            chk("op",     32'(op_o),     32'(m_op));
            chk("result", 32'(result_o), 32'(m_res));
            chk("valid",  32'(valid_o),  32'(m_valid));
            chk("err",    32'(err_o),    32'(m_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_state = 0; m_a = '0; m_b = '0; m_op = '0;
        m_res = '0; m_valid = 1'b0; m_err = 1'b0;
    endtask

    // Effect of one accepted button press on the model
    task automatic model_press();
        case (m_state)
            0: begin m_a = sw; m_valid = 1'b0; m_err = 1'b0; m_state = 1; end
            1: begin m_b = sw; m_state = 2; end
            2: begin
                m_op = op_sw;
                if (op_sw == 2'b11 && m_b == 6'd0) begin
                    m_res = 12'hFFF; m_err = 1'b1; m_valid = 1'b0; m_state = 4;
                end else begin
                    m_state = 3;
                end
            end
            4: begin m_valid = 1'b0; m_err = 1'b0; m_state = 0; end
            default: ;
        endcase
    endtask

    // Button rises before edge 1; the FSM acts on edge 8. EXEC captures two edges later.
    task automatic press(int hold);
        btn = 1'b1;
        repeat (7) tick();
        tick();
        model_press();
        if (m_state == 3) begin
            tick();
            tick();
            m_res = alu_fn(m_a, m_b, m_op);
            m_valid = 1'b1;
            m_state = 4;
        end
        repeat (hold) tick();
        btn = 1'b0;
        repeat (10) tick();
    endtask

    task automatic run_op(logic [5:0] a, logic [5:0] b, logic [1:0] op);
        sw = a;    press(2);
        sw = b;    press(2);
        op_sw = op; press(2);
    endtask

    initial begin
        rst_n = 1'b0; btn = 1'b0; sw = '0; op_sw = '0;
        model_reset();
        repeat (2) tick();
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_led",   32'(led_o),   32'd1);
        chk("rst_A",     32'(a_o),     32'd0);
        chk("rst_res",   32'(result_o), 32'd0);
        chk("rst_flags", 32'({valid_o, err_o}), 32'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        tick();

        // Short glitch is filtered
        sw = 6'd21;
        btn = 1'b1;
        repeat (3) tick();
        btn = 1'b0;
        repeat (12) tick();
        chk("glitch_state", 32'(state_o), 32'd0);

        // Long hold produces one load only
        sw = 6'd5;
        press(25);
        chk("hold_state", 32'(state_o), 32'd1);
        chk("hold_A",     32'(a_o),     32'd5);

        sw = 6'd3;  press(2);
        op_sw = 2'b00; press(2);
        chk("add_res",   32'(result_o), 32'd8);
        chk("add_valid", 32'(valid_o),  32'd1);
        chk("add_led",   32'(led_o),    32'd0);
        press(2);
        chk("add_back", 32'({state_o, valid_o}), 32'd0);

        run_op(6'h3E, 6'd3, 2'b10);
        chk("mul_res", 32'(result_o), 32'hFFA);
        chk("mul_valid", 32'(valid_o), 32'd1);
        press(2);

        run_op(6'd5, 6'd7, 2'b01);
        chk("sub_res", 32'(result_o), 32'hFFE);
        press(2);

        run_op(6'd7, 6'd2, 2'b11);
        chk("div_res", 32'(result_o), 32'd3);
        press(2);

        run_op(6'd7, 6'd0, 2'b11);
        chk("dz_res",   32'(result_o), 32'hFFF);
        chk("dz_flags", 32'({valid_o, err_o}), 32'b01);
        chk("dz_state", 32'(state_o), 32'd4);
        press(2);
        chk("dz_clear", 32'({state_o, err_o}), 32'd0);

        // Reset arriving during EXEC
        sw = 6'd9; press(2);
        sw = 6'd1; press(2);
        op_sw = 2'b00;
        btn = 1'b1;
        repeat (8) tick();
        model_press();
        chk("abort_exec", 32'(state_o), 32'd3);
        rst_n = 1'b0;
        btn = 1'b0;
        tick();
        model_reset();
        chk("abort_state", 32'(state_o), 32'd0);
        chk("abort_valid", 32'(valid_o), 32'd0);
        chk("abort_A",     32'(a_o),     32'd0);
        chk("abort_led",   32'(led_o),   32'd1);
        rst_n = 1'b1;
        repeat (10) tick();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
